tcp_slow_path_send_q: RTL and testbench
=======================================

Name: tcp_slow_path_send_q

Overview:
- Buffers control packets generated by the TCP slow-path RX datapath (SYN-ACK header plus IP pair on the slow_path_send_pkt_enqueue_* bus) and hands them to the TX header/packet assembly pipeline.
- Sits directly downstream of the slow-path RX datapath.
- Decouples the slow-path RX FSM from TX back-pressure with a small FIFO and a val/rdy output stage.
- Keeps occupancy and sent/stall statistics for debug.

Parameters:
- DEPTH, 4, number of queued packets; power of two, >=2.
- DEPTH_W, $clog2(DEPTH), pointer width.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- slow_path_send_pkt_enqueue_val  in  1  enqueue request
- slow_path_send_pkt_enqueue_rdy  out  1  queue can accept
- slow_path_send_pkt_enqueue_pkt  in  tcp_pkt_hdr  TCP header to send
- slow_path_send_pkt_enqueue_src_ip  in  IP_ADDR_W  IP source of outgoing packet
- slow_path_send_pkt_enqueue_dst_ip  in  IP_ADDR_W  IP destination of outgoing packet
- slow_path_send_pkt_val  out  1  head packet valid to TX
- slow_path_send_pkt_rdy  in  1  TX accepts head packet
- slow_path_send_pkt_hdr  out  tcp_pkt_hdr  head TCP header
- slow_path_send_pkt_src_ip  out  IP_ADDR_W  head source IP
- slow_path_send_pkt_dst_ip  out  IP_ADDR_W  head destination IP
- send_q_occupancy  out  DEPTH_W+1  entries held, including the output register
- send_q_sent_cnt  out  CNT_W  packets dequeued, saturating
- send_q_stall_cnt  out  CNT_W  cycles with enqueue_val=1 and enqueue_rdy=0, saturating

Behaviour:
- Reset (rst=1 at posedge) clears all of the following. Data-array contents are don't-care.
  - rd/wr pointers, occupancy and both counters go to 0.
  - slow_path_send_pkt_val goes to 0; hdr/src_ip/dst_ip go to 0.
  - enqueue_rdy is 1 in the cycle after reset deasserts.
- Reset mid-operation discards all queued packets. A transfer in the reset cycle does not count.
- Storage:
  - Circular array of DEPTH entries {hdr, src_ip, dst_ip} with wr_ptr/rd_ptr of DEPTH_W+1 bits; the MSB distinguishes full from empty on wrap.
  - A separate output register (valid bit + payload) feeds the TX port, so total capacity is DEPTH+1.
- Enqueue:
  - enqueue_rdy = !array_full, registered-state only; it never depends on deq rdy in the same cycle.
  - Enqueue fires when val&&rdy. The entry is written at wr_ptr and wr_ptr increments, wrapping naturally.
- Output stage:
  - States EMPTY (val=0) and HOLD (val=1).
  - EMPTY -> HOLD: when the array is non-empty, load the head entry into the output register next cycle.
  - EMPTY -> HOLD (bypass): when the array is empty and an enqueue fires, load enqueue data directly. Enqueue-to-val latency is exactly 1 cycle.
  - HOLD: outputs stay stable while rdy=0; no payload change is allowed while val=1 and rdy=0.
  - HOLD with rdy=1, array non-empty: reload from array head the next cycle and stay in HOLD, giving back-to-back throughput of 1 packet/cycle.
  - HOLD with rdy=1, array empty, simultaneous enqueue: bypass-load the new packet and stay in HOLD.
  - HOLD with rdy=1, array empty, no enqueue: go to EMPTY.
- Ordering: packets leave in strict enqueue order. Bypass is used only when the array is empty, which preserves order.
- Simultaneous enqueue and array-pop in the same cycle:
  - The array count is unchanged and both pointers advance.
  - Legal even when the array is full; enqueue_rdy was 0 that cycle, so no enqueue occurs.
- send_q_occupancy = array count + output valid, updated each cycle; max DEPTH+1.
- send_q_sent_cnt increments on val&&rdy and saturates at all-ones.
- send_q_stall_cnt increments on enqueue_val&&!enqueue_rdy and saturates at all-ones.
- Header and IPs pass through unmodified. No checksum or field rewriting is done here; the TX assembler owns that.

Test Plan:
- Single packet: after reset, enqueue hdr{seq=0xff, ack=0x1235, flags=SYN|ACK}, src_ip=0x0a000001, dst_ip=0x0a000002, with TX rdy=1.
  - Required: val=1 exactly 1 cycle later with identical fields.
  - Required: sent_cnt=1, occupancy back to 0.
- Fill/back-pressure (DEPTH=4): TX rdy=0, enqueue 6 packets with seq 1..6 on consecutive cycles.
  - Required: 5 accepted (occupancy=5); enqueue_rdy=0 from the 6th, stall_cnt increments each waiting cycle.
  - Required: after rdy=1, packets come out seq 1,2,3,4,5 then 6 with no gaps.
- Streaming: continuous enqueue with rdy=1 for 20 cycles.
  - Required: one packet out per cycle, in order; occupancy never exceeds 2; pointers wrap correctly past DEPTH.
- Stall hold: val=1 with rdy=0 for 10 cycles while 2 more packets are enqueued.
  - Required: output fields unchanged for all 10 cycles.
- Reset mid-operation: 3 packets queued, assert rst for 1 cycle.
  - Required: val=0, occupancy=0, counters=0 next cycle.
  - Required: a fresh packet enqueued afterwards comes out first.
- Counter saturation (CNT_W=4): dequeue 20 packets.
  - Required: sent_cnt stops at 15.

Source files
------------

// File: rtl/tcp_slow_path_send_q.sv
// Slow-path control packet send queue.
// Small FIFO plus output register between slow-path RX and TX assembly.
package tcp_pkg;

    localparam int IP_ADDR_W = 32;

    localparam logic [7:0] TCP_FLAG_SYN = 8'h02;
    localparam logic [7:0] TCP_FLAG_ACK = 8'h10;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [7:0]  flags;
        logic [15:0] window;
    } tcp_pkt_hdr;

    typedef struct packed {
        tcp_pkt_hdr           hdr;
        logic [IP_ADDR_W-1:0] src_ip;
        logic [IP_ADDR_W-1:0] dst_ip;
    } send_entry_t;

endpackage

module tcp_slow_path_send_q
    import tcp_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = $clog2(DEPTH),
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 slow_path_send_pkt_enqueue_val,
    output logic                 slow_path_send_pkt_enqueue_rdy,
    input  tcp_pkt_hdr           slow_path_send_pkt_enqueue_pkt,
    input  logic [IP_ADDR_W-1:0] slow_path_send_pkt_enqueue_src_ip,
    input  logic [IP_ADDR_W-1:0] slow_path_send_pkt_enqueue_dst_ip,
    output logic                 slow_path_send_pkt_val,
    input  logic                 slow_path_send_pkt_rdy,
    output tcp_pkt_hdr           slow_path_send_pkt_hdr,
    output logic [IP_ADDR_W-1:0] slow_path_send_pkt_src_ip,
    output logic [IP_ADDR_W-1:0] slow_path_send_pkt_dst_ip,
    output logic [DEPTH_W:0]     send_q_occupancy,
    output logic [CNT_W-1:0]     send_q_sent_cnt,
    output logic [CNT_W-1:0]     send_q_stall_cnt
);

    typedef enum logic {
        EMPTY,
        HOLD
    } out_state_t;

    out_state_t  state;
    out_state_t  state_nxt;

    send_entry_t mem [DEPTH];
    send_entry_t enq_data;
    send_entry_t out_q;

    logic [DEPTH_W:0] wr_ptr;
    logic [DEPTH_W:0] rd_ptr;
    logic [DEPTH_W:0] arr_cnt;
    logic             arr_empty;
    logic             arr_full;
    logic             enq_fire;
    logic             deq_fire;
    logic             do_pop;
    logic             do_byp;
    logic             do_wr;

    assign enq_data = '{
        hdr:    slow_path_send_pkt_enqueue_pkt,
        src_ip: slow_path_send_pkt_enqueue_src_ip,
        dst_ip: slow_path_send_pkt_enqueue_dst_ip
    };

    // Extra pointer MSB separates full from empty after wrap.
    assign arr_cnt   = wr_ptr - rd_ptr;
    assign arr_empty = (wr_ptr == rd_ptr);
    assign arr_full  = arr_cnt[DEPTH_W];

    assign slow_path_send_pkt_enqueue_rdy = !arr_full;

    assign enq_fire = slow_path_send_pkt_enqueue_val
                    && slow_path_send_pkt_enqueue_rdy;
    assign deq_fire = (state == HOLD) && slow_path_send_pkt_rdy;

    // Bypass only when the array is empty so order is preserved.
    assign do_wr = enq_fire && !do_byp;

    assign slow_path_send_pkt_val    = (state == HOLD);
    assign slow_path_send_pkt_hdr    = out_q.hdr;
    assign slow_path_send_pkt_src_ip = out_q.src_ip;
    assign slow_path_send_pkt_dst_ip = out_q.dst_ip;

    assign send_q_occupancy = arr_cnt
                            + {{DEPTH_W{1'b0}}, (state == HOLD)};

    // Output stage state register.
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Output stage next state: refill when empty or when the head leaves.
    always_comb begin
        state_nxt = state;
        do_pop    = 1'b0;
        do_byp    = 1'b0;
        if ((state == EMPTY) || deq_fire) begin
            if (!arr_empty) begin
                do_pop    = 1'b1;
                state_nxt = HOLD;
            end else if (enq_fire) begin
                do_byp    = 1'b1;
                state_nxt = HOLD;
            end else begin
                state_nxt = EMPTY;
            end
        end
    end

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[DEPTH_W-1:0]] <= enq_data;
    end

    // Pointers and output payload register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            out_q  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                out_q  <= mem[rd_ptr[DEPTH_W-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end else if (do_byp) begin
                out_q  <= enq_data;
            end
        end
    end

    // Saturating sent and stall statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            send_q_sent_cnt  <= '0;
            send_q_stall_cnt <= '0;
        end else begin
            if (deq_fire && (send_q_sent_cnt != '1))
                send_q_sent_cnt <= send_q_sent_cnt + 1'b1;
            if (slow_path_send_pkt_enqueue_val
                && !slow_path_send_pkt_enqueue_rdy
                && (send_q_stall_cnt != '1))
                send_q_stall_cnt <= send_q_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tcp_slow_path_send_q.sv
// Bench for tcp_slow_path_send_q.
// Scoreboard of accepted packets checked against the TX port.
module tb_tcp_slow_path_send_q;
    import tcp_pkg::*;

    localparam int DEPTH   = 4;
    localparam int DEPTH_W = 2;
    localparam int CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 enq_val = 1'b0;
    logic                 enq_rdy;
    tcp_pkt_hdr           enq_pkt = '0;
    logic [IP_ADDR_W-1:0] enq_src = '0;
    logic [IP_ADDR_W-1:0] enq_dst = '0;
    logic                 tx_val;
    logic                 tx_rdy = 1'b0;
    tcp_pkt_hdr           tx_hdr;
    logic [IP_ADDR_W-1:0] tx_src;
    logic [IP_ADDR_W-1:0] tx_dst;
    logic [DEPTH_W:0]     occ;
    logic [CNT_W-1:0]     sent_cnt;
    logic [CNT_W-1:0]     stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    send_entry_t      sb[$];
    logic [CNT_W-1:0] sent_m  = '0;
    logic [CNT_W-1:0] stall_m = '0;
    bit               stream_on = 1'b0;

    tcp_slow_path_send_q #(
        .DEPTH(DEPTH),
        .DEPTH_W(DEPTH_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .slow_path_send_pkt_enqueue_val(enq_val),
        .slow_path_send_pkt_enqueue_rdy(enq_rdy),
        .slow_path_send_pkt_enqueue_pkt(enq_pkt),
        .slow_path_send_pkt_enqueue_src_ip(enq_src),
        .slow_path_send_pkt_enqueue_dst_ip(enq_dst),
        .slow_path_send_pkt_val(tx_val),
        .slow_path_send_pkt_rdy(tx_rdy),
        .slow_path_send_pkt_hdr(tx_hdr),
        .slow_path_send_pkt_src_ip(tx_src),
        .slow_path_send_pkt_dst_ip(tx_dst),
        .send_q_occupancy(occ),
        .send_q_sent_cnt(sent_cnt),
        .send_q_stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic send_entry_t mk(input int s);
        send_entry_t e;
        e.hdr.src_port = 16'h1000 + 16'(s);
        e.hdr.dst_port = 16'd80;
        e.hdr.seq_num  = 32'(s);
        e.hdr.ack_num  = 32'h1235 + 32'(s * 3);
        e.hdr.flags    = TCP_FLAG_SYN | TCP_FLAG_ACK;
        e.hdr.window   = 16'hffff - 16'(s);
        e.src_ip       = 32'h0a000000 + 32'(s);
        e.dst_ip       = 32'h0b000000 + 32'(s);
        return e;
    endfunction

    // Monitor: model checks, scoreboard pop on dequeue, push on enqueue.
    always @(negedge clk) begin
        send_entry_t e;
        if (rst) begin
            sb.delete();
            sent_m  = '0;
            stall_m = '0;
        end else begin
            check("occupancy", 128'(occ), 128'(sb.size()));
            check("tx_val", 128'(tx_val), 128'(sb.size() != 0));
            check("enq_rdy", 128'(enq_rdy), 128'(sb.size() <= DEPTH));
            check("sent_cnt", 128'(sent_cnt), 128'(sent_m));
            check("stall_cnt", 128'(stall_cnt), 128'(stall_m));
            if (stream_on) check("occ_le2", 128'(occ <= 2), 128'(1));
            if (tx_val && tx_rdy) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    check("out_hdr", 128'(tx_hdr), 128'(e.hdr));
                    check("out_src", 128'(tx_src), 128'(e.src_ip));
                    check("out_dst", 128'(tx_dst), 128'(e.dst_ip));
                end
                if (sent_m != CNT_MAX) sent_m = sent_m + 1'b1;
            end
            if (enq_val && enq_rdy) begin
                e = '{hdr: enq_pkt, src_ip: enq_src, dst_ip: enq_dst};
                sb.push_back(e);
            end
            if (enq_val && !enq_rdy && stall_m != CNT_MAX)
                stall_m = stall_m + 1'b1;
        end
    end

    task automatic drive(input send_entry_t e);
        enq_val = 1'b1;
        enq_pkt = e.hdr;
        enq_src = e.src_ip;
        enq_dst = e.dst_ip;
    endtask

    // Present one packet and hold it until the queue accepts it.
    task automatic send(input send_entry_t e);
        bit ok;
        ok = 1'b0;
        drive(e);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (enq_rdy) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) check("enq_timeout", 128'(0), 128'(1));
        enq_val = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        send_entry_t e;
        send_entry_t hold;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_val", 128'(tx_val), 128'(0));
        check("rst_rdy", 128'(enq_rdy), 128'(1));
        check("rst_hdr", 128'(tx_hdr), 128'(0));
        check("rst_occ", 128'(occ), 128'(0));
        @(posedge clk);
        #1;

        // Single packet, TX ready.
        tx_rdy = 1'b1;
        e.hdr.src_port = 16'd1234;
        e.hdr.dst_port = 16'd80;
        e.hdr.seq_num  = 32'hff;
        e.hdr.ack_num  = 32'h1235;
        e.hdr.flags    = TCP_FLAG_SYN | TCP_FLAG_ACK;
        e.hdr.window   = 16'h4000;
        e.src_ip       = 32'h0a000001;
        e.dst_ip       = 32'h0a000002;
        drive(e);
        @(negedge clk);
        check("single_val_pre", 128'(tx_val), 128'(0));
        @(posedge clk);
        #1 enq_val = 1'b0;
        @(negedge clk);
        check("single_val", 128'(tx_val), 128'(1));
        check("single_hdr", 128'(tx_hdr), 128'(e.hdr));
        check("single_src", 128'(tx_src), 128'(32'h0a000001));
        check("single_dst", 128'(tx_dst), 128'(32'h0a000002));
        @(negedge clk);
        check("single_sent", 128'(sent_cnt), 128'(1));
        check("single_occ", 128'(occ), 128'(0));
        @(posedge clk);
        #1;

        // Fill with TX stalled: five fit, the sixth waits.
        tx_rdy = 1'b0;
        for (int s = 1; s <= 5; s++) send(mk(s));
        drive(mk(6));
        @(negedge clk);
        check("fill_occ", 128'(occ), 128'(DEPTH + 1));
        check("fill_rdy0", 128'(enq_rdy), 128'(0));
        repeat (2) begin
            @(negedge clk);
            check("fill_rdy0", 128'(enq_rdy), 128'(0));
        end
        @(posedge clk);
        #1 tx_rdy = 1'b1;
        @(negedge clk);
        check("fill_stall", 128'(stall_cnt), 128'(3));
        @(posedge clk);
        #1;
        send(mk(6));
        drain();

        // Streaming: one packet per cycle, wraps the pointers.
        stream_on = 1'b1;
        for (int s = 10; s < 30; s++) send(mk(s));
        drain();
        @(negedge clk);
        stream_on = 1'b0;
        @(posedge clk);
        #1;

        // Stall hold: head must not change while TX is not ready.
        tx_rdy = 1'b0;
        send(mk(40));
        @(negedge clk);
        hold = '{hdr: tx_hdr, src_ip: tx_src, dst_ip: tx_dst};
        check("hold_first", 128'(hold), 128'(mk(40)));
        @(posedge clk);
        #1;
        fork
            begin
                send(mk(41));
                send(mk(42));
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    check("hold_stable",
                          128'({tx_val, tx_hdr, tx_src, tx_dst}),
                          128'({1'b1, hold}));
                end
            end
        join
        @(posedge clk);
        #1 tx_rdy = 1'b1;
        drain();

        // Reset with packets queued.
        tx_rdy = 1'b0;
        for (int s = 50; s < 53; s++) send(mk(s));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_val", 128'(tx_val), 128'(0));
        check("mid_rst_occ", 128'(occ), 128'(0));
        check("mid_rst_sent", 128'(sent_cnt), 128'(0));
        check("mid_rst_stall", 128'(stall_cnt), 128'(0));
        @(posedge clk);
        #1;
        send(mk(99));
        @(negedge clk);
        check("post_rst_first", 128'(tx_hdr.seq_num), 128'(99));
        @(posedge clk);
        #1 tx_rdy = 1'b1;
        drain();

        // Saturation: 20 more packets past a 4-bit counter.
        for (int s = 100; s < 120; s++) send(mk(s));
        drain();
        @(negedge clk);
        check("sent_sat", 128'(sent_cnt), 128'(15));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
